// File: rtl/cpu_clock_controller.sv
// CPU clock source for a hobby CPU: free-running divided clock or debounced single-step pulses.
// Outputs a registered ClkOut, a 32-bit rising-edge counter and a Busy flag.
module cpu_clock_controller #(
  parameter int DIV_COUNT      = 50000000,
  parameter int DEBOUNCE_COUNT = 1000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RunMode,
  input  logic        StepBtn,
  output logic        ClkOut,
  output logic [31:0] StepCount,
  output logic        Busy
);

  localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int DB_W  = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(DIV_COUNT - 1);
  localparam logic [DB_W-1:0]  DB_TERM  = DB_W'(DEBOUNCE_COUNT - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_PULSE_HI = 2'd2;
  localparam logic [1:0] S_PULSE_LO = 2'd3;

  logic             r_run_meta;
  logic             r_run_sync;
  logic             r_btn_meta;
  logic             r_btn_sync;
  logic             r_db_level;
  logic             r_db_prev;
  logic [DB_W-1:0]  r_db_cnt;
  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div;
  logic             r_clk_out;
  logic [31:0]      r_step_count;

  logic             w_step_req;
  logic             w_div_term;
  logic [1:0]       w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_clk_nxt;
  logic             w_clk_rise;

  // Two-flop synchronizers for the asynchronous switch and button.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_run_meta <= 1'b0;
      r_run_sync <= 1'b0;
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_run_meta <= RunMode;
      r_run_sync <= r_run_meta;
      r_btn_meta <= StepBtn;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Debouncer: accept a new level only after DEBOUNCE_COUNT consecutive differing cycles.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
      r_db_cnt   <= '0;
    end else begin
      r_db_prev <= r_db_level;
      if (r_btn_sync != r_db_level) begin
        if (r_db_cnt == DB_TERM) begin
          r_db_level <= r_btn_sync;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_step_req = r_db_level & ~r_db_prev;
  assign w_div_term = (r_div == DIV_TERM);

  // Next-state logic; ClkOut's next value is computed here but only ever leaves through a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_clk_nxt   = r_clk_out;
    case (r_state)
      S_IDLE: begin
        w_div_nxt = '0;
        w_clk_nxt = 1'b0;
        if (r_run_sync) begin
          w_state_nxt = S_RUN;
        end else if (w_step_req) begin
          w_state_nxt = S_PULSE_HI;
          w_clk_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (!r_run_sync && !r_clk_out) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
          w_clk_nxt   = 1'b0;
        end else if (w_div_term) begin
          w_div_nxt = '0;
          if (!r_run_sync) begin
            // Stop request while high: finish the high phase, then park low.
            w_clk_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_clk_nxt = ~r_clk_out;
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_PULSE_HI: begin
        if (w_div_term) begin
          w_div_nxt   = '0;
          w_clk_nxt   = 1'b0;
          w_state_nxt = S_PULSE_LO;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_PULSE_LO: begin
        if (w_div_term) begin
          w_div_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_div_nxt   = '0;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  assign w_clk_rise = w_clk_nxt & ~r_clk_out;

  // State, divider, ClkOut and step counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      r_clk_out    <= 1'b0;
      r_step_count <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_clk_out <= w_clk_nxt;
      if (w_clk_rise) begin
        r_step_count <= r_step_count + 32'd1;
      end else begin
        r_step_count <= r_step_count;
      end
    end
  end

  assign ClkOut    = r_clk_out;
  assign StepCount = r_step_count;
  assign Busy      = (r_state != S_IDLE);

endmodule

// File: doc/cpu_clock_controller.md
CPU_CLOCK_CONTROLLER -- requirements
Module: cpu_clock_controller

Interface
REQ-001 Parameter DIV_COUNT, default 50000000: board-clock cycles per ClkOut half-period.
REQ-002 Parameter DEBOUNCE_COUNT, default 1000000: consecutive stable cycles required to accept a new StepBtn level.
REQ-003 Port Clk  input  1  board clock; all logic rising-edge triggered on Clk; single clock domain.
REQ-004 Port Reset  input  1  reset; asynchronous assertion, active-low (Reset=0 resets).
REQ-005 Port RunMode  input  1  asynchronous switch; 1 = free-run, 0 = single-step.
REQ-006 Port StepBtn  input  1  raw, bouncing, asynchronous push-button; 1 = pressed.
REQ-007 Port ClkOut  output  1  registered CPU clock; drives the CPU clock and the display stage downstream.
REQ-008 Port StepCount  output  32  count of ClkOut rising edges since reset.
REQ-009 Port Busy  output  1  high whenever state is not IDLE.

Function
REQ-010 RunMode and StepBtn SHALL each pass through a 2-flop synchronizer before use.
REQ-011 Debouncer: debounced level SHALL take the synchronized StepBtn value only after it differs from the current debounced level for DEBOUNCE_COUNT consecutive cycles; any mismatch break clears the stability counter.
REQ-012 StepReq SHALL be a 1-cycle pulse on a debounced 0->1 transition; no pulse on 1->0.
REQ-013 FSM states: IDLE, RUN, PULSE_HI, PULSE_LO; one shared divider counter, range 0..DIV_COUNT-1; terminal = DIV_COUNT-1.
REQ-014 IDLE: ClkOut=0, divider held at 0; synced RunMode=1 -> RUN; else StepReq=1 -> PULSE_HI with ClkOut set to 1 on the same edge.
REQ-015 RUN: divider increments each cycle; at terminal, ClkOut toggles and divider returns to 0; ClkOut period = 2*DIV_COUNT cycles, 50% duty; first rising edge DIV_COUNT cycles after RUN entry.
REQ-016 RUN with synced RunMode=0: if ClkOut=0, go to IDLE on the next edge; if ClkOut=1, continue to the next terminal, drive ClkOut to 0 and go to IDLE on that edge; no truncated high phase.
REQ-017 PULSE_HI: after DIV_COUNT cycles, ClkOut<=0 -> PULSE_LO; PULSE_LO: after DIV_COUNT cycles -> IDLE.
REQ-018 StepReq in any state other than IDLE SHALL be dropped, not queued.
REQ-019 RunMode changes during PULSE_HI/PULSE_LO SHALL NOT abort the pulse; they are evaluated once IDLE is reached.
REQ-020 ClkOut SHALL come directly from a flop, never from combinational logic, and SHALL be glitch-free.
REQ-021 StepCount SHALL increment by 1 on every cycle in which ClkOut goes 0->1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-022 Busy SHALL be combinational from state: 0 in IDLE, 1 otherwise.

Reset
REQ-023 Reset=0 SHALL immediately set: state IDLE, ClkOut 0, Busy 0, StepCount 0, divider 0, debounce counter 0, debounced level 0, synchronizer flops 0.
REQ-024 Reset deassertion SHALL cause no ClkOut edge and no StepReq, even if StepBtn is held high. A held button reads as debounced 1 only after DEBOUNCE_COUNT cycles and produces exactly one step.
REQ-025 Reset asserted during any pulse SHALL abort it; no completion after release.

Verification (DIV_COUNT=4, DEBOUNCE_COUNT=3)
REQ-026 RunMode=1 from reset: ClkOut has period 8, high 4/low 4; StepCount=3 after the 3rd rising edge; Busy=1 throughout.
REQ-027 RunMode=0, StepBtn held 1 for 10 cycles: exactly one ClkOut pulse, high 4 then low 4; StepCount 0->1; Busy high 8 cycles, then 0.
REQ-028 StepBtn toggles every cycle for 12 cycles, then 0: no StepReq, ClkOut stays 0, StepCount unchanged.
REQ-029 Second clean press during PULSE_HI: ignored; StepCount increments by 1 total.
REQ-030 RunMode 1->0 while ClkOut=1 in RUN: ClkOut falls at the next terminal count, then stays 0 in IDLE; no further rising edges.
REQ-031 Reset=0 asserted mid-PULSE_HI with StepCount=5: ClkOut=0 and StepCount=0 asynchronously; after release and 20 idle cycles, no ClkOut edge.
